dat_fifo: RTL and testbench

- Synchronous word FIFO between the host-side data source/sink and dat_phys on the SD DAT path.
- Write direction (writeRead=1): supplies the 32-bit dataFROMFIFO words that dat_phys serialises.
- Read direction (writeRead=0): absorbs the words dat_phys deserialises.
- Generates the fifo_okay flow-control flag consumed by dat_controller: a whole block can be moved without stalling.

---
 rtl/dat_defs.sv | 15 +
 rtl/dat_fifo_if.sv | 33 +++
 rtl/dat_fifo_ptr.sv | 28 ++
 rtl/dat_fifo.sv | 125 ++++++++++++
 tb/tb_dat_fifo.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dat_defs.sv
// dat_defs: shared constants for the SD DAT-path FIFO.
//   DAT_DATA_WIDTH  - default word width
//   DAT_ADDR_WIDTH  - default pointer width (depth = 2**DAT_ADDR_WIDTH)
//   DAT_BLOCK_WORDS - default words per data block (fifo_okay threshold)
//   WR_DIR / RD_DIR - encodings of writeRead (host->card / card->host)
package dat_defs;

    localparam int unsigned DAT_DATA_WIDTH  = 32;
    localparam int unsigned DAT_ADDR_WIDTH  = 4;
    localparam int unsigned DAT_BLOCK_WORDS = 4;

    localparam logic WR_DIR = 1'b1;
    localparam logic RD_DIR = 1'b0;

endpackage

// File: rtl/dat_fifo_if.sv
// dat_fifo_if: handshake/bus bundle between the host-side source/sink and dat_fifo.
//   master - drives clear, writeRead, write_en, write_data, read_en;
//            observes read_data, full, empty, count, fifo_okay, overflow, underflow
//   slave  - the FIFO side (directions reversed)
interface dat_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);

    logic                  clear;
    logic                  writeRead;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  fifo_okay;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, writeRead, write_en, write_data, read_en,
        input  read_data, full, empty, count, fifo_okay, overflow, underflow
    );

    modport slave (
        input  clear, writeRead, write_en, write_data, read_en,
        output read_data, full, empty, count, fifo_okay, overflow, underflow
    );

endinterface

// File: rtl/dat_fifo_ptr.sv
// dat_fifo_ptr: wrapping pointer register for dat_fifo.
//   clock - clock
//   reset - synchronous active-high reset to 0
//   clear - synchronous flush to 0
//   inc   - advance by one, wrapping modulo 2**ADDR_WIDTH
//   ptr   - current pointer value
module dat_fifo_ptr #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    // Natural binary overflow provides the wrap from depth-1 back to 0.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/dat_fifo.sv
// dat_fifo: synchronous word FIFO on the SD DAT path.
//   clock - single clock
//   reset - synchronous active-high reset
//   bus   - dat_fifo_if.slave: clear, writeRead, push/pop handshake, read_data,
//           full/empty/count, fifo_okay, sticky overflow/underflow
// Build option: define DAT_FIFO_FWFT_EN for first-word fall-through reads;
// otherwise read_data is registered with one cycle of latency.
module dat_fifo
    import dat_defs::*;
#(
    parameter int unsigned DATA_WIDTH  = DAT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DAT_ADDR_WIDTH,
    parameter int unsigned BLOCK_WORDS = DAT_BLOCK_WORDS
) (
    input logic       clock,
    input logic       reset,
    dat_fifo_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_BLOCK = (ADDR_WIDTH + 1)'(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [ADDR_WIDTH:0]   free_words;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push;
    logic                  pop;
    logic                  push_rej;
    logic                  pop_rej;

    // A flush swallows any push/pop (and their rejections) in the same cycle.
    assign push     = bus.write_en && !full_q  && !bus.clear;
    assign pop      = bus.read_en  && !empty_q && !bus.clear;
    assign push_rej = bus.write_en &&  full_q  && !bus.clear;
    assign pop_rej  = bus.read_en  &&  empty_q && !bus.clear;

    dat_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (bus.clear),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    dat_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clear (bus.clear),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (bus.clear) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // full/empty are registered from count_d so they track count exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_DEPTH);
            empty_q <= (count_d == '0);
            if (push_rej) overflow_q  <= 1'b1;
            if (pop_rej)  underflow_q <= 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.write_data;
        end
    end

`ifdef DAT_FIFO_FWFT_EN
    assign bus.read_data = empty_q ? '0 : mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            rdata_q <= '0;
        end else if (pop) begin
            rdata_q <= mem[rd_ptr];
        end
    end

    assign bus.read_data = rdata_q;
`endif

    assign free_words    = CNT_DEPTH - count_q;
    assign bus.fifo_okay = (bus.writeRead == WR_DIR) ? (count_q >= CNT_BLOCK)
                                                     : (free_words >= CNT_BLOCK);

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_dat_fifo.sv
// tb_dat_fifo: self-checking bench for dat_fifo. A queue-based model tracks
// expected contents and sticky flags; a negedge compare process checks every
// output each cycle, and directed sequences add literal expectations.
module tb_dat_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BLK   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    dat_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dat_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BLK)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Specification-level model: queue of stored words plus sticky flags.
    task automatic model_update();
        bit m_full;
        bit m_empty;
        if (reset) begin
            mq.delete();
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (bus.clear) begin
            mq.delete();
            m_rdata = '0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            if (bus.write_en && m_full)  m_ovf = 1'b1;
            if (bus.read_en  && m_empty) m_unf = 1'b1;
            if (bus.read_en && !m_empty) m_rdata = mq.pop_front();
            if (bus.write_en && !m_full) mq.push_back(bus.write_data);
        end
    endtask

    function automatic logic exp_okay();
        int n = mq.size();
        return bus.writeRead ? (n >= BLK) : ((DEPTH - n) >= BLK);
    endfunction

    function automatic logic [DW-1:0] exp_rdata();
`ifdef DAT_FIFO_FWFT_EN
        return (mq.size() == 0) ? '0 : mq[0];
`else
        return m_rdata;
`endif
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_count",     64'(bus.count),     64'(mq.size()));
            check("cmp_full",      64'(bus.full),      64'(mq.size() == DEPTH));
            check("cmp_empty",     64'(bus.empty),     64'(mq.size() == 0));
            check("cmp_fifo_okay", 64'(bus.fifo_okay), 64'(exp_okay()));
            check("cmp_overflow",  64'(bus.overflow),  64'(m_ovf));
            check("cmp_underflow", 64'(bus.underflow), 64'(m_unf));
            check("cmp_read_data", 64'(bus.read_data), 64'(exp_rdata()));
        end
    end

    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    // One cycle of push and/or pop; a pop checks its word at the point it is valid.
    task automatic xfer(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic [DW-1:0] exp, input string nm);
        bus.write_en   = we;
        bus.write_data = wd;
        bus.read_en    = re;
`ifdef DAT_FIFO_FWFT_EN
        if (re) check(nm, 64'(bus.read_data), 64'(exp));
`endif
        step();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
`ifndef DAT_FIFO_FWFT_EN
        if (re) check(nm, 64'(bus.read_data), 64'(exp));
`endif
    endtask

    task automatic push(input logic [DW-1:0] wd);
        xfer(1'b1, wd, 1'b0, '0, "push");
    endtask

    task automatic pop(input logic [DW-1:0] exp, input string nm);
        xfer(1'b0, '0, 1'b1, exp, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] first4 [4];
    logic [DW-1:0] v;
    logic [DW-1:0] e;

    initial begin
        first4[0] = 32'hAB45FEDC;
        first4[1] = 32'h00000001;
        first4[2] = 32'h00000002;
        first4[3] = 32'h00000003;

        bus.clear      = 1'b0;
        bus.writeRead  = 1'b1;
        bus.write_en   = 1'b0;
        bus.write_data = '0;
        bus.read_en    = 1'b0;

        // Reset and idle
        step();
        step();
        reset = 1'b0;
        chk_en = 1'b1;
        step();
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full",  64'(bus.full),  64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_okay_wr", 64'(bus.fifo_okay), 64'd0);
        bus.writeRead = 1'b0;
        #1;
        check("rst_okay_rd", 64'(bus.fifo_okay), 64'd1);
        bus.writeRead = 1'b1;

        // Four pushes: fifo_okay rises exactly when count reaches the block size
        for (int i = 0; i < 4; i++) begin
            push(first4[i]);
            check("blk_okay", 64'(bus.fifo_okay), (i == 3) ? 64'd1 : 64'd0);
        end
        check("blk_count", 64'(bus.count), 64'd4);
        for (int i = 0; i < 4; i++) pop(first4[i], "blk_pop");
        check("blk_empty", 64'(bus.empty), 64'd1);

        // Fill to full, then reject one push
        for (int i = 0; i < 16; i++) push(32'h1000_0000 + 32'(i));
        check("full_flag",  64'(bus.full),  64'd1);
        check("full_count", 64'(bus.count), 64'd16);
        push(32'hDEAD_BEEF);
        check("ovf_count", 64'(bus.count),    64'd16);
        check("ovf_flag",  64'(bus.overflow), 64'd1);
        bus.writeRead = 1'b0;
        #1;
        check("full_okay_rd", 64'(bus.fifo_okay), 64'd0);
        bus.writeRead = 1'b1;
        for (int i = 0; i < 16; i++) pop(32'h1000_0000 + 32'(i), "full_drain");

        // Underflow and simultaneous push+pop on empty
        pop(32'h1000_000F, "unf_pop_hold");
        check("unf_flag",  64'(bus.underflow), 64'd1);
        check("unf_count", 64'(bus.count),     64'd0);
        bus.write_en   = 1'b1;
        bus.write_data = 32'hFABCDE40;
        bus.read_en    = 1'b1;
        step();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        check("pp_empty_count", 64'(bus.count), 64'd1);
        pop(32'hFABCDE40, "pp_empty_pop");

        // Three fill/drain rounds with concurrent traffic at half level
        v = 32'hC000_0000;
        e = 32'hC000_0000;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                push(v);
                v++;
            end
            for (int i = 0; i < 8; i++) begin
                xfer(1'b1, v, 1'b1, e, "conc_pop");
                v++;
                e++;
                check("conc_count", 64'(bus.count), 64'd8);
            end
            for (int i = 0; i < 8; i++) begin
                push(v);
                v++;
            end
            check("round_full", 64'(bus.full), 64'd1);
            for (int i = 0; i < 16; i++) begin
                pop(e, "round_drain");
                e++;
            end
        end

        // Clear retains sticky flags, reset clears everything
        for (int i = 0; i < 10; i++) push(32'h5000_0000 + 32'(i));
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clr_count", 64'(bus.count),     64'd0);
        check("clr_empty", 64'(bus.empty),     64'd1);
        check("clr_ovf",   64'(bus.overflow),  64'd1);
        check("clr_unf",   64'(bus.underflow), 64'd1);
        check("clr_rdata", 64'(bus.read_data), 64'd0);
        push(32'h6000_0001);
        push(32'h6000_0002);
        bus.write_en   = 1'b1;
        bus.write_data = 32'h6000_0003;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.write_en = 1'b0;
        check("rst2_count", 64'(bus.count),     64'd0);
        check("rst2_empty", 64'(bus.empty),     64'd1);
        check("rst2_full",  64'(bus.full),      64'd0);
        check("rst2_ovf",   64'(bus.overflow),  64'd0);
        check("rst2_unf",   64'(bus.underflow), 64'd0);
        check("rst2_rdata", 64'(bus.read_data), 64'd0);
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
